div_period_monitor: RTL and testbench

// - Downstream checker for the fractional M/N clock divider; consumes its divided output as data in the source clock domain.
// - Measures each divided-clock period and high time in input-clock cycles and checks every period is floor(M/N) or ceil(M/N).
// - Over every window of N periods, also checks that the window totals exactly M input cycles.
// - Used in simulation and in-system as a divider health monitor.

---
 rtl/div_period_monitor_pkg.sv | 22 ++
 rtl/div_period_monitor_win_accum.sv | 62 ++++++
 rtl/div_period_monitor.sv | 126 ++++++++++++
 tb/tb_div_period_monitor.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_period_monitor_pkg.sv
// Shared types and helpers for the divided-clock period monitor.
package div_period_monitor_pkg;

  // Arming sequence: a rise only counts once div_in has been seen low after
  // reset, and the first counted rise only opens the first period.
  typedef enum logic [1:0] {
    ST_WAIT_LOW  = 2'd0,
    ST_WAIT_RISE = 2'd1,
    ST_ARMED     = 2'd2
  } arm_state_t;

  // Shortest legal period for an M/N divider.
  function automatic int p_floor(input int m, input int n);
    return m / n;
  endfunction

  // Longest legal period for an M/N divider.
  function automatic int p_ceil(input int m, input int n);
    return (m + n - 1) / n;
  endfunction

endpackage

// File: rtl/div_period_monitor_win_accum.sv
// Window accumulator: sums N measured periods and compares the total to M.
module div_win_accum
  import div_period_monitor_pkg::*;
#(
  parameter int M     = 87,
  parameter int N     = 10,
  parameter int CNT_W = 8,
  parameter int SUM_W = 10
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             i_rise,
  input  logic [CNT_W-1:0] i_cnt,
  input  logic             i_clr,
  output logic [SUM_W-1:0] o_win_sum,
  output logic             o_win_vld,
  output logic             o_win_ok
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [IDX_W-1:0] r_idx;
  logic [SUM_W-1:0] r_acc;
  logic [SUM_W:0]   w_sum_full;
  logic [SUM_W-1:0] w_sum;
  logic             w_last;

  // Saturate the running sum so a run of stuck periods cannot wrap into a
  // value that happens to equal M.
  assign w_sum_full = {1'b0, r_acc} + (SUM_W+1)'(i_cnt);
  assign w_sum      = w_sum_full[SUM_W] ? {SUM_W{1'b1}} : w_sum_full[SUM_W-1:0];
  assign w_last     = (r_idx == IDX_W'(N - 1));

  // Accumulate each measured period; publish and restart at the Nth.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_idx     <= '0;
      r_acc     <= '0;
      o_win_sum <= '0;
      o_win_vld <= 1'b0;
      o_win_ok  <= 1'b0;
    end else begin
      o_win_vld <= 1'b0;
      if (i_clr) begin
        r_idx <= '0;
        r_acc <= '0;
      end else if (i_rise) begin
        if (w_last) begin
          r_idx     <= '0;
          r_acc     <= '0;
          o_win_sum <= w_sum;
          o_win_ok  <= (w_sum == SUM_W'(M));
          o_win_vld <= 1'b1;
        end else begin
          r_idx <= r_idx + IDX_W'(1);
          r_acc <= w_sum;
        end
      end
    end
  end

endmodule

// File: rtl/div_period_monitor.sv
// Health monitor for an M/N fractional clock divider: measures every divided
// period and high time in clk_in cycles, flags illegal periods and stuck
// inputs, and checks that every N periods total exactly M cycles.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_WAIT_LOW  | after reset; waiting to see div_in low (ignores held-high)
// ST_WAIT_RISE | first qualified rise pending; it starts period one only
// ST_ARMED     | every qualified rise closes a period and reports it
module div_period_monitor
  import div_period_monitor_pkg::*;
#(
  parameter int M     = 87,
  parameter int N     = 10,
  parameter int CNT_W = 8,
  parameter int SUM_W = 10
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             div_in,
  input  logic             clr,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_cnt,
  output logic             period_vld,
  output logic [SUM_W-1:0] win_sum,
  output logic             win_vld,
  output logic             win_ok,
  output logic             err_period,
  output logic             err_ovf
);

  localparam logic [CNT_W-1:0] P_FLOOR = CNT_W'(p_floor(M, N));
  localparam logic [CNT_W-1:0] P_CEIL  = CNT_W'(p_ceil(M, N));
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  arm_state_t       r_state;
  logic             r_div_q;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hcnt;
  logic             w_rise;
  logic             w_meas;

  // A rise is only trusted once div_in has been low since reset.
  assign w_rise = div_in & ~r_div_q & (r_state != ST_WAIT_LOW);
  assign w_meas = w_rise & (r_state == ST_ARMED);

  // Previous-cycle copy of div_in for edge detection.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) r_div_q <= 1'b0;
    else      r_div_q <= div_in;
  end

  // Arming sequence; clr deliberately leaves this untouched.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_state <= ST_WAIT_LOW;
    end else begin
      case (r_state)
        ST_WAIT_LOW:  if (!div_in) r_state <= ST_WAIT_RISE;
        ST_WAIT_RISE: if (w_rise)  r_state <= ST_ARMED;
        ST_ARMED:     r_state <= ST_ARMED;
        default:      r_state <= ST_WAIT_LOW;
      endcase
    end
  end

  // Period and high-time counters, restarted on each rise and saturating.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_hcnt <= '0;
    end else if (w_rise) begin
      r_cnt  <= CNT_W'(1);
      r_hcnt <= {{(CNT_W-1){1'b0}}, div_in};
    end else begin
      if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
      if (div_in && (r_hcnt != CNT_MAX)) r_hcnt <= r_hcnt + CNT_W'(1);
    end
  end

  // Publish the finished period one cycle after the rise that closes it.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      period     <= '0;
      high_cnt   <= '0;
      period_vld <= 1'b0;
    end else begin
      period_vld <= w_meas;
      if (w_meas) begin
        period   <= r_cnt;
        high_cnt <= r_hcnt;
      end
    end
  end

  // Sticky health flags; clr takes priority over a same-cycle set.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      err_period <= 1'b0;
      err_ovf    <= 1'b0;
    end else if (clr) begin
      err_period <= 1'b0;
      err_ovf    <= 1'b0;
    end else begin
      if (w_meas && (r_cnt != P_FLOOR) && (r_cnt != P_CEIL)) err_period <= 1'b1;
      if (r_cnt == CNT_MAX) err_ovf <= 1'b1;
    end
  end

  div_win_accum #(
    .M     (M),
    .N     (N),
    .CNT_W (CNT_W),
    .SUM_W (SUM_W)
  ) u_win_accum (
    .clk_in    (clk_in),
    .rst       (rst),
    .i_rise    (w_meas),
    .i_cnt     (r_cnt),
    .i_clr     (clr),
    .o_win_sum (win_sum),
    .o_win_vld (win_vld),
    .o_win_ok  (win_ok)
  );

endmodule

// File: tb/tb_div_period_monitor.sv
// Scoreboard bench for div_period_monitor: periods are driven as whole
// (length, high-time) pairs and the expected reports are queued from them.
module tb_div_period_monitor;

  localparam int M     = 87;
  localparam int N     = 10;
  localparam int CNT_W = 8;
  localparam int SUM_W = 10;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam int SMAX  = (1 << SUM_W) - 1;

  logic             clk_in = 1'b0;
  logic             rst;
  logic             div_in;
  logic             clr;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_cnt;
  logic             period_vld;
  logic [SUM_W-1:0] win_sum;
  logic             win_vld;
  logic             win_ok;
  logic             err_period;
  logic             err_ovf;

  always #5 clk_in = ~clk_in;

  div_period_monitor #(.M(M), .N(N), .CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .div_in     (div_in),
    .clr        (clr),
    .period     (period),
    .high_cnt   (high_cnt),
    .period_vld (period_vld),
    .win_sum    (win_sum),
    .win_vld    (win_vld),
    .win_ok     (win_ok),
    .err_period (err_period),
    .err_ovf    (err_ovf)
  );

  typedef struct {
    int p;
    int h;
  } per_t;

  int   n_vec = 0;
  int   n_err = 0;
  per_t q_per[$];
  int   q_wsum[$];

  // Reference model state, at the level of whole periods.
  bit   m_armed;
  int   m_cur_p;
  int   m_cur_h;
  int   m_win[$];
  bit   m_err_p;
  bit   m_err_o;

  int   pat_ideal[10] = '{9, 9, 8, 9, 9, 8, 9, 9, 8, 9};

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input logic v, input logic c);
    div_in = v;
    clr    = c;
    @(posedge clk_in);
    #1;
  endtask

  // A rise ends the period in flight: queue what the monitor must report.
  task automatic close_period();
    int mp;
    int mh;
    int s;
    if (m_armed) begin
      mp = imin(m_cur_p, CMAX);
      mh = imin(m_cur_h, CMAX);
      q_per.push_back('{mp, mh});
      if (mp != M / N && mp != (M + N - 1) / N) m_err_p = 1'b1;
      m_win.push_back(mp);
      if (m_win.size() == N) begin
        s = 0;
        foreach (m_win[i]) s += m_win[i];
        q_wsum.push_back(imin(s, SMAX));
        m_win.delete();
      end
    end
    m_armed = 1'b1;
  endtask

  task automatic drive_period(input int p, input int h, input int clr_at);
    close_period();
    m_cur_p = p;
    m_cur_h = h;
    for (int i = 0; i < p; i++) begin
      if (i == clr_at) begin
        m_err_p = 1'b0;
        m_err_o = 1'b0;
        m_win.delete();
      end
      tick(i < h, i == clr_at);
    end
    if (p > CMAX) m_err_o = 1'b1;
    check("err_period", int'(err_period), int'(m_err_p));
    check("err_ovf", int'(err_ovf), int'(m_err_o));
  endtask

  task automatic drive_ideal_window();
    for (int i = 0; i < N; i++) drive_period(pat_ideal[i], pat_ideal[i] / 2, -1);
  endtask

  task automatic do_reset(input bit hold_high);
    rst    = 1'b0;
    div_in = hold_high;
    clr    = 1'b0;
    #2;
    check("rst_period", int'(period), 0);
    check("rst_high_cnt", int'(high_cnt), 0);
    check("rst_period_vld", int'(period_vld), 0);
    check("rst_win_sum", int'(win_sum), 0);
    check("rst_win_vld", int'(win_vld), 0);
    check("rst_win_ok", int'(win_ok), 0);
    check("rst_err_period", int'(err_period), 0);
    check("rst_err_ovf", int'(err_ovf), 0);
    check("rst_pending_periods", q_per.size(), 0);
    m_armed = 1'b0;
    m_err_p = 1'b0;
    m_err_o = 1'b0;
    m_win.delete();
    tick(hold_high, 1'b0);
    tick(hold_high, 1'b0);
    rst = 1'b1;
    if (hold_high) begin
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
    end
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
  endtask

  // Monitor: every report the DUT makes must match the head of its queue.
  always begin
    per_t e;
    int   s;
    @(negedge clk_in);
    if (rst === 1'b1) begin
      if (period_vld) begin
        if (q_per.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_period_vld: got period %0d expected no report at %0t", period, $time);
        end else begin
          e = q_per.pop_front();
          check("period", int'(period), e.p);
          check("high_cnt", int'(high_cnt), e.h);
        end
      end
      if (win_vld) begin
        if (q_wsum.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_win_vld: got win_sum %0d expected no report at %0t", win_sum, $time);
        end else begin
          s = q_wsum.pop_front();
          check("win_sum", int'(win_sum), s);
          check("win_ok", int'(win_ok), int'(s == M));
        end
      end
    end
  end

  initial begin
    int p;
    int h;
    int ca;
    m_armed = 1'b0;
    m_cur_p = 0;
    m_cur_h = 0;
    m_err_p = 1'b0;
    m_err_o = 1'b0;

    do_reset(1'b0);

    // First rise arms silently, then three ideal windows.
    for (int w = 0; w < 3; w++) drive_ideal_window();

    // One period of 10 inside a window, then a clean window.
    for (int i = 0; i < N; i++) drive_period((i == 4) ? 10 : pat_ideal[i], 4, -1);
    drive_ideal_window();

    // div_in stuck low long enough to saturate the period counter.
    drive_period(300, 4, -1);
    for (int i = 0; i < N; i++) drive_period(pat_ideal[i], 5, -1);

    // Reset in the middle of a window, with div_in held high across release.
    for (int i = 0; i < 5; i++) drive_period(pat_ideal[i], 3, -1);
    do_reset(1'b1);
    drive_ideal_window();
    drive_period(9, 4, -1);

    // Set err_period, then clear it mid-period and build a fresh window.
    drive_period(12, 6, -1);
    drive_period(9, 4, -1);
    drive_period(8, 3, 4);
    for (int i = 1; i < N; i++) drive_period(pat_ideal[i], 4, -1);
    drive_ideal_window();

    // Randomized periods, mostly legal, with occasional clr pulses.
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(99, 0) < 88) p = 8 + int'($urandom_range(1, 0));
      else p = int'($urandom_range(13, 5));
      h  = int'($urandom_range(p - 1, 1));
      ca = ($urandom_range(99, 0) < 4) ? int'($urandom_range(p - 1, 1)) : -1;
      drive_period(p, h, ca);
    end

    // Close the last period and let the monitor drain.
    drive_period(9, 4, -1);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0);
    check("leftover_periods", q_per.size(), 0);
    check("leftover_windows", q_wsum.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
